enq_pkt_desc_rd: RTL and testbench

Drain side of the enqueue packet-descriptor FIFO. The block pops `enq_pkt_desc_type` entries from a registered-output synchronous FIFO and forwards each one downstream as a single-cycle `desc_valid` strobe. Forwarding is paced by a credit counter that the downstream queue manager replenishes with `credit_return` pulses. The block sits between the descriptor FIFO's read port and the queue-manager enqueue interface.

---
 rtl/enq_pkt_desc_rd.sv | 134 +++++++++++++
 tb/tb_enq_pkt_desc_rd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/enq_pkt_desc_rd.sv
// enq_pkt_desc_rd: drain side of the enqueue packet-descriptor FIFO.
// Pops descriptors from a registered-output FIFO and forwards each one as a
// single-cycle desc_valid strobe, paced by a credit counter that the queue
// manager replenishes with credit_return pulses.
// Optional feature: define ENQ_PKT_DESC_RD_STATS_EN to enable the sent_cnt
// statistics counter; otherwise sent_cnt is tied to 0.

`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

package enq_pkt_desc_pkg;
   typedef struct packed {
      logic [5:0]  qid;
      logic [13:0] len;
      logic [11:0] ptr;
   } enq_pkt_desc_type;
endpackage

module enq_pkt_desc_rd
   import enq_pkt_desc_pkg::*;
#(
   parameter int CREDIT_NBITS = 4,
   parameter int CREDIT_INIT  = 8
) (
   input  logic                    clk,
   input  logic                    `RESET_SIG,
   input  logic                    enable,
   input  logic                    fifo_empty,
   input  enq_pkt_desc_type        fifo_dout,
   output logic                    fifo_rd,
   output logic                    desc_valid,
   output enq_pkt_desc_type        desc,
   input  logic                    credit_return,
   output logic [CREDIT_NBITS-1:0] credit_cnt,
   output logic                    credit_err,
   output logic [31:0]             sent_cnt
);

   typedef enum logic [1:0] {INIT, RUN, NOCRED, OFF} state_t;

   // One extra bit so a return at full credit is visible as overflow.
   localparam logic [CREDIT_NBITS:0] CMAX  = {1'b0, {CREDIT_NBITS{1'b1}}};
   localparam logic [CREDIT_NBITS:0] CINIT = (CREDIT_NBITS+1)'(CREDIT_INIT);

   state_t                  state, state_next;
   logic [CREDIT_NBITS:0]   cnt_sum;
   logic                    cnt_ovf;
   logic [CREDIT_NBITS-1:0] cnt_next;
   logic                    cnt_zero;

   // State is RUN only when the registered count is nonzero, so a pop never
   // underflows the counter.
   assign fifo_rd = (state == RUN) & enable & ~fifo_empty;

   // Next credit count: INIT loads the initial credits, otherwise pops
   // consume and returns replenish; saturate at the maximum.
   always_comb begin
      cnt_sum = '0;
      if (state == INIT)
         cnt_sum = CINIT + {{CREDIT_NBITS{1'b0}}, credit_return};
      else
         cnt_sum = {1'b0, credit_cnt} - {{CREDIT_NBITS{1'b0}}, fifo_rd}
                   + {{CREDIT_NBITS{1'b0}}, credit_return};
   end

   assign cnt_ovf  = (cnt_sum > CMAX);
   assign cnt_next = cnt_ovf ? CMAX[CREDIT_NBITS-1:0] : cnt_sum[CREDIT_NBITS-1:0];
   assign cnt_zero = (cnt_next == '0);

   // Next-state: enable low always wins (OFF), otherwise the next credit
   // count chooses between RUN and NOCRED.
   always_comb begin
      state_next = state;
      case (state)
         INIT: begin
            if (!enable)       state_next = OFF;
            else if (cnt_zero) state_next = NOCRED;
            else               state_next = RUN;
         end
         RUN: begin
            if (!enable)       state_next = OFF;
            else if (cnt_zero) state_next = NOCRED;
         end
         NOCRED: begin
            if (!enable)       state_next = OFF;
            else if (!cnt_zero) state_next = RUN;
         end
         OFF: begin
            if (enable)        state_next = cnt_zero ? NOCRED : RUN;
         end
         default: state_next = INIT;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) state <= INIT;
      else             state <= state_next;
   end

   // Credit counter and sticky overflow flag.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) begin
         credit_cnt <= '0;
         credit_err <= 1'b0;
      end else begin
         credit_cnt <= cnt_next;
         if (cnt_ovf) credit_err <= 1'b1;
      end
   end

   // Capture the FIFO head on a pop and strobe it out the next cycle.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) begin
         desc_valid <= 1'b0;
         desc       <= '0;
      end else begin
         desc_valid <= fifo_rd;
         if (fifo_rd) desc <= fifo_dout;
      end
   end

`ifdef ENQ_PKT_DESC_RD_STATS_EN
   // Forwarded-descriptor count, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG)     sent_cnt <= '0;
      else if (desc_valid) sent_cnt <= sent_cnt + 32'd1;
   end
`else
   assign sent_cnt = '0;
`endif

endmodule

// File: tb/tb_enq_pkt_desc_rd.sv
// Testbench for enq_pkt_desc_rd: directed scenarios followed by random
// traffic, checked against a transaction-level reference model (FIFO as a
// queue, credits as an integer, pop rule stated in terms of enable history).

`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

module tb_enq_pkt_desc_rd;
   import enq_pkt_desc_pkg::*;

   localparam int NB   = 4;
   localparam int CI   = 8;
   localparam int CMAX = (1 << NB) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             enable = 1'b0;
   logic             fifo_empty = 1'b1;
   enq_pkt_desc_type fifo_dout = '0;
   logic             fifo_rd;
   logic             desc_valid;
   enq_pkt_desc_type desc;
   logic             credit_return = 1'b0;
   logic [NB-1:0]    credit_cnt;
   logic             credit_err;
   logic [31:0]      sent_cnt;

   always #5 clk = ~clk;

   enq_pkt_desc_rd #(.CREDIT_NBITS(NB), .CREDIT_INIT(CI)) dut (
      .clk          (clk),
      .`RESET_SIG   (rst_n),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_dout    (fifo_dout),
      .fifo_rd      (fifo_rd),
      .desc_valid   (desc_valid),
      .desc         (desc),
      .credit_return(credit_return),
      .credit_cnt   (credit_cnt),
      .credit_err   (credit_err),
      .sent_cnt     (sent_cnt)
   );

   int checks = 0;
   int errors = 0;
   int n_dv   = 0;

   enq_pkt_desc_type fq[$];

   // Reference model state
   int               m_cred = 0;
   bit               m_err = 0, m_init = 0, m_en_prev = 0, m_dv = 0;
   enq_pkt_desc_type m_desc = '0;
   int unsigned      m_sent = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fifo_refresh();
      fifo_empty = (fq.size() == 0);
      if (fq.size() != 0) fifo_dout = fq[0];
   endtask

   task automatic push(input enq_pkt_desc_type d);
      fq.push_back(d);
      fifo_refresh();
   endtask

   function automatic enq_pkt_desc_type rnd_desc();
      enq_pkt_desc_type d;
      d = enq_pkt_desc_type'($urandom);
      return d;
   endfunction

   task automatic chk_sent(input string tag);
`ifdef ENQ_PKT_DESC_RD_STATS_EN
      chk(tag, sent_cnt, m_sent);
`else
      chk(tag, sent_cnt, 0);
`endif
   endtask

   // One clock cycle: starts and ends just after a falling edge.
   task automatic cyc(input bit en, input bit ret);
      bit exp_rd;
      int s;
      enable = en;
      credit_return = ret;
      #1;
      // Pops happen only past the init cycle, with enable high now and in
      // the previous cycle, credits available and data present.
      exp_rd = !m_init && m_en_prev && en && (fq.size() != 0) && (m_cred > 0);
      chk("fifo_rd", fifo_rd, exp_rd);
      @(posedge clk);
      if (m_dv) m_sent++;
      m_dv = exp_rd;
      if (exp_rd) m_desc = fq.pop_front();
      s = m_init ? CI + int'(ret) : m_cred - int'(exp_rd) + int'(ret);
      if (s > CMAX) begin
         s = CMAX;
         m_err = 1;
      end
      m_cred = s;
      m_en_prev = en;
      m_init = 0;
      #1;
      fifo_refresh();
      if (desc_valid === 1'b1) n_dv++;
      chk("desc_valid", desc_valid, m_dv);
      chk("desc", desc, m_desc);
      chk("credit_cnt", credit_cnt, m_cred);
      chk("credit_err", credit_err, m_err);
      chk_sent("sent_cnt");
      @(negedge clk);
   endtask

   // Assert reset, check that outputs clear without a clock edge, release.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_desc_valid", desc_valid, 0);
      chk("rst_desc", desc, 0);
      chk("rst_credit_cnt", credit_cnt, 0);
      chk("rst_credit_err", credit_err, 0);
      chk("rst_sent_cnt", sent_cnt, 0);
      m_cred = 0; m_err = 0; m_dv = 0; m_desc = '0; m_sent = 0;
      m_init = 1; m_en_prev = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset();

      // Credit-limited burst: 10 queued, only 8 forwarded.
      for (int i = 0; i < 10; i++) push(rnd_desc());
      n_dv = 0;
      repeat (12) cyc(1, 0);
      chk("burst_count", n_dv, 8);
      chk("burst_cred0", credit_cnt, 0);
      chk("burst_left", fq.size(), 2);

      // Single credit return releases exactly one descriptor.
      cyc(1, 1);
      chk("ret_cred1", credit_cnt, 1);
      cyc(1, 0);
      cyc(1, 0);
      chk("ret_left", fq.size(), 1);

      // Simultaneous pop and return hold the count steady.
      for (int i = 0; i < 6; i++) push(rnd_desc());
      repeat (3) cyc(0, 1);
      cyc(1, 0);
      chk("sim_cred3", credit_cnt, 3);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1);
         chk("sim_hold3", credit_cnt, 3);
      end

      // Overflow with an empty FIFO.
      fq.delete();
      fifo_refresh();
      do_reset();
      cyc(1, 0);
      repeat (7) cyc(1, 1);
      chk("ovf_full", credit_cnt, 15);
      chk("ovf_noerr", credit_err, 0);
      cyc(1, 1);
      chk("ovf_sat", credit_cnt, 15);
      chk("ovf_err", credit_err, 1);
      repeat (3) cyc(1, 0);
      chk("ovf_sticky", credit_err, 1);

      // Enable drop in the cycle D2 would pop.
      do_reset();
      for (int i = 0; i < 6; i++) push(rnd_desc());
      n_dv = 0;
      cyc(1, 0);
      cyc(1, 0);
      cyc(1, 0);
      cyc(0, 0);
      cyc(1, 0);
      repeat (6) cyc(1, 0);
      chk("en_count", n_dv, 6);
      chk("en_left", fq.size(), 0);
`ifdef ENQ_PKT_DESC_RD_STATS_EN
      chk("en_sent", sent_cnt, 6);
`else
      chk("en_sent", sent_cnt, 0);
`endif

      // Mid-stream reset while a descriptor is on the output.
      do_reset();
      for (int i = 0; i < 4; i++) push(rnd_desc());
      cyc(1, 0);
      cyc(1, 0);
      chk("mrst_dv", desc_valid, 1);
      do_reset();
      cyc(1, 0);
      chk("mrst_init", credit_cnt, CI);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) push(rnd_desc());
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
